// File: rtl/grf_wport_arb_pkg.sv
// Shared CPU constants used by the GRF write-port arbiter: register-address
// width and the grant_id source encodings.
package grf_wport_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef enum logic [1:0] {
        GNT_WB   = 2'd0,
        GNT_R1   = 2'd1,
        GNT_R2   = 2'd2,
        GNT_NONE = 2'd3
    } grant_e;

endpackage

// File: rtl/grf_wport_arb_rr_pick2.sv
// Two-way round-robin pick. A lone requester always wins; with both
// requesting, the one not granted last wins. last_r2=1 favours requester 1.
module rr_pick2 (
    input  logic en,
    input  logic req1,
    input  logic req2,
    input  logic last_r2,
    output logic gnt1,
    output logic gnt2
);

    // Combinational pick, suppressed entirely when en is low.
    always_comb begin
        gnt1 = 1'b0;
        gnt2 = 1'b0;
        if (en) begin
            if (req1 && req2) begin
                gnt1 = last_r2;
                gnt2 = !last_r2;
            end else begin
                gnt1 = req1;
                gnt2 = req2;
            end
        end
    end

endmodule

// File: rtl/grf_wport_arb.sv
// GRF write-port arbiter: pipeline writeback has absolute priority, the MDU
// (r1) and CP0 (r2) results share the leftover slots round-robin. The winner
// is registered onto the GRF write port one cycle after acceptance.
// Optional feature macro: GRF_ARB_ANTISTARVE_EN adds per-requester wait
// counters that raise stall_pipe when a requester has been blocked too long.
module grf_wport_arb
    import grf_wport_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  r1_valid,
    input  logic [REG_ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0]     r1_data,
    output logic                  r1_ready,
    input  logic                  r2_valid,
    input  logic [REG_ADDR_W-1:0] r2_addr,
    input  logic [DATA_W-1:0]     r2_data,
    output logic                  r2_ready,
    output logic                  RegWr,
    output logic [REG_ADDR_W-1:0] RWAddr,
    output logic [DATA_W-1:0]     RWData,
    output logic [1:0]            grant_id,
    output logic                  stall_pipe
);

    logic                  wb_req;
    logic                  xfer1;
    logic                  xfer2;
    logic                  reg_wr_q,  reg_wr_d;
    logic [REG_ADDR_W-1:0] rw_addr_q, rw_addr_d;
    logic [DATA_W-1:0]     rw_data_q, rw_data_d;
    logic [1:0]            grant_q,   grant_d;
    logic                  last_r2_q, last_r2_d;

    // A write to $0 is a no-op, so it does not claim the port.
    assign wb_req = wb_we && (wb_addr != '0);

    rr_pick2 u_pick (
        .en      (!Reset && !wb_req),
        .req1    (r1_valid),
        .req2    (r2_valid),
        .last_r2 (last_r2_q),
        .gnt1    (r1_ready),
        .gnt2    (r2_ready)
    );

    assign xfer1 = r1_valid && r1_ready;
    assign xfer2 = r2_valid && r2_ready;

    // Select this cycle's winner and advance the round-robin pointer on r1/r2 transfers.
    always_comb begin
        reg_wr_d  = 1'b0;
        rw_addr_d = '0;
        rw_data_d = '0;
        grant_d   = GNT_NONE;
        last_r2_d = last_r2_q;
        if (wb_req) begin
            reg_wr_d  = 1'b1;
            rw_addr_d = wb_addr;
            rw_data_d = wb_data;
            grant_d   = GNT_WB;
        end else if (xfer1) begin
            reg_wr_d  = (r1_addr != '0);
            rw_addr_d = r1_addr;
            rw_data_d = r1_data;
            grant_d   = GNT_R1;
            last_r2_d = 1'b0;
        end else if (xfer2) begin
            reg_wr_d  = (r2_addr != '0);
            rw_addr_d = r2_addr;
            rw_data_d = r2_data;
            grant_d   = GNT_R2;
            last_r2_d = 1'b1;
        end
    end

    // Write-port register and pointer; reset drops any pending write and favours r1.
    always_ff @(posedge clk) begin
        if (Reset) begin
            reg_wr_q  <= 1'b0;
            rw_addr_q <= '0;
            rw_data_q <= '0;
            grant_q   <= GNT_NONE;
            last_r2_q <= 1'b1;
        end else begin
            reg_wr_q  <= reg_wr_d;
            rw_addr_q <= rw_addr_d;
            rw_data_q <= rw_data_d;
            grant_q   <= grant_d;
            last_r2_q <= last_r2_d;
        end
    end

    assign RegWr    = reg_wr_q;
    assign RWAddr   = rw_addr_q;
    assign RWData   = rw_data_q;
    assign grant_id = grant_q;

`ifdef GRF_ARB_ANTISTARVE_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] wait1_q, wait1_d;
    logic [CNT_W-1:0] wait2_q, wait2_d;
    logic             stall_q, stall_d;

    // Count blocked cycles per requester, saturating; stall while either is saturated.
    always_comb begin
        wait1_d = wait1_q;
        wait2_d = wait2_q;
        if (!r1_valid || xfer1) begin
            wait1_d = '0;
        end else if (wait1_q != CNT_MAX) begin
            wait1_d = wait1_q + CNT_W'(1);
        end
        if (!r2_valid || xfer2) begin
            wait2_d = '0;
        end else if (wait2_q != CNT_MAX) begin
            wait2_d = wait2_q + CNT_W'(1);
        end
        stall_d = (wait1_d == CNT_MAX) || (wait2_d == CNT_MAX);
    end

    // Wait counters and registered stall request.
    always_ff @(posedge clk) begin
        if (Reset) begin
            wait1_q <= '0;
            wait2_q <= '0;
            stall_q <= 1'b0;
        end else begin
            wait1_q <= wait1_d;
            wait2_q <= wait2_d;
            stall_q <= stall_d;
        end
    end

    assign stall_pipe = stall_q;
`else
    assign stall_pipe = 1'b0;
`endif

endmodule

// File: tb/tb_grf_wport_arb.sv
// Bench for grf_wport_arb: directed scenarios followed by random traffic,
// all checked against a behavioural model of the arbitration rules.
module tb_grf_wport_arb;

    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        Reset;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        r1_valid;
    logic [4:0]  r1_addr;
    logic [31:0] r1_data;
    logic        r1_ready;
    logic        r2_valid;
    logic [4:0]  r2_addr;
    logic [31:0] r2_data;
    logic        r2_ready;
    logic        RegWr;
    logic [4:0]  RWAddr;
    logic [31:0] RWData;
    logic [1:0]  grant_id;
    logic        stall_pipe;

    always #5 clk = ~clk;

    grf_wport_arb #(.STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .r1_valid   (r1_valid),
        .r1_addr    (r1_addr),
        .r1_data    (r1_data),
        .r1_ready   (r1_ready),
        .r2_valid   (r2_valid),
        .r2_addr    (r2_addr),
        .r2_data    (r2_data),
        .r2_ready   (r2_ready),
        .RegWr      (RegWr),
        .RWAddr     (RWAddr),
        .RWData     (RWData),
        .grant_id   (grant_id),
        .stall_pipe (stall_pipe)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: which requester was granted last (1 or 2),
    // blocked-cycle counts, and the expected registered outputs.
    int          last_src = 2;
    int          wait1 = 0;
    int          wait2 = 0;
    bit          e_known = 0;
    logic        e_wr;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [1:0]  e_gid;
    logic        e_stall;
    bit          x1 = 0;
    bit          x2 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Falling edge: compare registered outputs with what the model predicted.
    task automatic begin_cycle();
        @(negedge clk);
        if (e_known) begin
            chk("RegWr", {31'd0, RegWr}, {31'd0, e_wr});
            chk("RWAddr", {27'd0, RWAddr}, {27'd0, e_addr});
            chk("RWData", RWData, e_data);
            chk("grant_id", {30'd0, grant_id}, {30'd0, e_gid});
            chk("stall_pipe", {31'd0, stall_pipe}, {31'd0, e_stall});
        end
    endtask

    // After inputs settle: check ready outputs, then advance the model.
    task automatic settle();
        bit wbq, er1, er2;
        #1;
        wbq = wb_we && (wb_addr != 5'd0);
        er1 = 0;
        er2 = 0;
        if (!Reset && !wbq) begin
            if (r1_valid && r2_valid) begin
                if (last_src == 2) er1 = 1;
                else er2 = 1;
            end else begin
                er1 = r1_valid;
                er2 = r2_valid;
            end
        end
        chk("r1_ready", {31'd0, r1_ready}, {31'd0, er1});
        chk("r2_ready", {31'd0, r2_ready}, {31'd0, er2});
        x1 = r1_valid && er1;
        x2 = r2_valid && er2;
        if (Reset) begin
            e_wr = 0; e_addr = 0; e_data = 0; e_gid = 2'd3; e_stall = 0;
            last_src = 2; wait1 = 0; wait2 = 0;
        end else begin
            if (wbq) begin
                e_wr = 1; e_addr = wb_addr; e_data = wb_data; e_gid = 2'd0;
            end else if (x1) begin
                e_wr = (r1_addr != 0); e_addr = r1_addr; e_data = r1_data; e_gid = 2'd1;
                last_src = 1;
            end else if (x2) begin
                e_wr = (r2_addr != 0); e_addr = r2_addr; e_data = r2_data; e_gid = 2'd2;
                last_src = 2;
            end else begin
                e_wr = 0; e_addr = 0; e_data = 0; e_gid = 2'd3;
            end
            wait1 = (!r1_valid || x1) ? 0 : ((wait1 < LIMIT) ? wait1 + 1 : LIMIT);
            wait2 = (!r2_valid || x2) ? 0 : ((wait2 < LIMIT) ? wait2 + 1 : LIMIT);
`ifdef GRF_ARB_ANTISTARVE_EN
            e_stall = (wait1 == LIMIT) || (wait2 == LIMIT);
`else
            e_stall = 0;
`endif
        end
        e_known = 1;
    endtask

    task automatic idle_inputs();
        Reset = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
        r1_valid = 0; r1_addr = 0; r1_data = 0;
        r2_valid = 0; r2_addr = 0; r2_data = 0;
    endtask

    task automatic do_reset();
        begin_cycle(); idle_inputs(); Reset = 1; settle();
        begin_cycle(); idle_inputs(); Reset = 1; settle();
    endtask

    initial begin
        idle_inputs();
        Reset = 1;

        // Reset state
        do_reset();
        begin_cycle();
        chk("rst_gid", {30'd0, grant_id}, 32'd3);
        chk("rst_wr", {31'd0, RegWr}, 32'd0);
        idle_inputs();
        settle();

        // Single r1 request, no wb
        begin_cycle(); idle_inputs();
        r1_valid = 1; r1_addr = 5; r1_data = 32'h1234;
        settle();
        chk("t028_ready", {31'd0, r1_ready}, 32'd1);
        begin_cycle();
        chk("t028_wr", {31'd0, RegWr}, 32'd1);
        chk("t028_addr", {27'd0, RWAddr}, 32'd5);
        chk("t028_data", RWData, 32'h1234);
        chk("t028_gid", {30'd0, grant_id}, 32'd1);
        idle_inputs(); settle();

        // wb blocks r1 for one cycle
        begin_cycle(); idle_inputs();
        wb_we = 1; wb_addr = 3; wb_data = 32'hCAFE0003;
        r1_valid = 1; r1_addr = 7; r1_data = 32'h77;
        settle();
        chk("t029_blk", {31'd0, r1_ready}, 32'd0);
        begin_cycle();
        chk("t029_addr", {27'd0, RWAddr}, 32'd3);
        chk("t029_gid", {30'd0, grant_id}, 32'd0);
        wb_we = 0; wb_addr = 0; wb_data = 0;
        settle();
        chk("t029_acc", {31'd0, r1_ready}, 32'd1);
        begin_cycle();
        chk("t029_gid1", {30'd0, grant_id}, 32'd1);
        idle_inputs(); settle();

        // Round-robin alternation from reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            begin_cycle();
            if (i > 0) chk("t030_gid", {30'd0, grant_id}, ((i - 1) % 2 == 0) ? 32'd1 : 32'd2);
            idle_inputs();
            r1_valid = 1; r1_addr = 10; r1_data = 32'hA1;
            r2_valid = 1; r2_addr = 11; r2_data = 32'hB2;
            settle();
            chk("t030_r1rdy", {31'd0, r1_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        begin_cycle();
        chk("t030_gid", {30'd0, grant_id}, 32'd2);
        idle_inputs(); settle();

        // wb to $0 does not block; r2 write to $0 is accepted but not written
        begin_cycle(); idle_inputs();
        wb_we = 1; wb_addr = 0; wb_data = 32'hDEAD;
        r2_valid = 1; r2_addr = 0; r2_data = 32'h55;
        settle();
        chk("t031_ready", {31'd0, r2_ready}, 32'd1);
        begin_cycle();
        chk("t031_wr", {31'd0, RegWr}, 32'd0);
        chk("t031_gid", {30'd0, grant_id}, 32'd2);
        idle_inputs(); settle();

        // Reset right after an r1 transfer
        begin_cycle(); idle_inputs();
        r1_valid = 1; r1_addr = 9; r1_data = 32'h99;
        settle();
        begin_cycle();
        Reset = 1;
        settle();
        chk("t032_r1rdy", {31'd0, r1_ready}, 32'd0);
        begin_cycle();
        chk("t032_wr", {31'd0, RegWr}, 32'd0);
        idle_inputs(); settle();

`ifdef GRF_ARB_ANTISTARVE_EN
        // Starvation: wb held 9 cycles while r1 waits
        do_reset();
        for (int i = 0; i < 9; i++) begin
            begin_cycle();
            if (i == 8) chk("t033_stall_on", {31'd0, stall_pipe}, 32'd1);
            idle_inputs();
            wb_we = 1; wb_addr = 9; wb_data = 32'h900 + i;
            r1_valid = 1; r1_addr = 4; r1_data = 32'h44;
            settle();
        end
        begin_cycle();
        chk("t033_stall_hold", {31'd0, stall_pipe}, 32'd1);
        idle_inputs();
        r1_valid = 1; r1_addr = 4; r1_data = 32'h44;
        settle();
        chk("t033_r1rdy", {31'd0, r1_ready}, 32'd1);
        begin_cycle();
        chk("t033_stall_off", {31'd0, stall_pipe}, 32'd0);
        chk("t033_gid", {30'd0, grant_id}, 32'd1);
        idle_inputs(); settle();
`endif

        // Random traffic; requesters keep addr/data stable until accepted
        do_reset();
        x1 = 0; x2 = 0;
        for (int i = 0; i < 400; i++) begin
            begin_cycle();
            Reset = ($urandom_range(0, 59) == 0);
            wb_we = ($urandom_range(0, 2) == 0);
            wb_addr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            wb_data = $urandom;
            if (x1 || !r1_valid) begin
                r1_valid = ($urandom_range(0, 2) != 0);
                r1_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                r1_data = $urandom;
            end
            if (x2 || !r2_valid) begin
                r2_valid = ($urandom_range(0, 2) != 0);
                r2_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                r2_data = $urandom;
            end
            settle();
        end
        begin_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
